// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver defaults and FSM state encoding
package uart_pkg;

   localparam int NB_DATA_DEF    = 8;
   localparam int OVERSAMPLE_DEF = 16;

   // One-hot state encoding
   localparam logic [3:0] ST_IDLE  = 4'b0001;
   localparam logic [3:0] ST_START = 4'b0010;
   localparam logic [3:0] ST_DATA  = 4'b0100;
   localparam logic [3:0] ST_STOP  = 4'b1000;

   typedef enum logic [3:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for the asynchronous serial line
module uart_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync
);

   logic meta;

   // Resets to 1 so an idle line is never mistaken for a start bit
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta   <= 1'b1;
         o_sync <= 1'b1;
      end else begin
         meta   <= i_async;
         o_sync <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1-style UART receiver
module uart_rx
   import uart_pkg::*;
#(
   parameter int NB_DATA    = NB_DATA_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_rx_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   output logic               o_frame_error
);

   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = $clog2(NB_DATA + 1);

   // Mid-bit point used to qualify the start bit, and end of a full bit period
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

   logic               rx_s;
   state_t             state,    state_n;
   logic [TW-1:0]      tick_cnt, tick_cnt_n;
   logic [BW-1:0]      bit_cnt,  bit_cnt_n;
   logic [NB_DATA-1:0] shift,    shift_n;
   logic [NB_DATA-1:0] data_n;
   logic               valid_n;
   logic               ferr_n;

   uart_sync u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_rx_data),
      .o_sync  (rx_s)
   );

   // State, counters, shift register and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_frame_error <= 1'b0;
      end else begin
         state         <= state_n;
         tick_cnt      <= tick_cnt_n;
         bit_cnt       <= bit_cnt_n;
         shift         <= shift_n;
         o_data        <= data_n;
         o_valid       <= valid_n;
         o_frame_error <= ferr_n;
      end
   end

   // Next-state logic; everything but IDLE->START waits for a tick
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift;
      data_n     = o_data;
      valid_n    = 1'b0;
      ferr_n     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n    = START;
               tick_cnt_n = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (tick_cnt == TICK_MID) begin
                  if (!rx_s) begin
                     state_n    = DATA;
                     tick_cnt_n = '0;
                     bit_cnt_n  = '0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n = '0;
                  shift_n    = (shift >> 1) | (NB_DATA'(rx_s) << (NB_DATA - 1));
                  bit_cnt_n  = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state_n = STOP;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n = '0;
                  state_n    = IDLE;
                  if (rx_s) begin
                     data_n  = shift;
                     valid_n = 1'b1;
                  end else begin
                     ferr_n = 1'b1;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule
